// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
// State encoding, default cycle counts and the counter-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAULT
  } pll_state_e;

  localparam int unsigned DEF_RST_PULSE_CYC    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_MAX_RETRY        = 3;

  // One counter is shared by every timed state, so size it for the longest.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock flag into the refclk domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification / core reset release sequencer (refclk domain).
// Define PLL_SEQ_LOCK_SYNC_EN to pass `locked` through a 2-flop synchronizer.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  localparam int unsigned CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  pll_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    retry_nxt;
  logic          lost_nxt;
  logic          locked_s;

`ifdef PLL_SEQ_LOCK_SYNC_EN
  pll_lock_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );
`else
  assign locked_s = locked;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost;
    if (relock_req) lost_nxt = 1'b0;

    unique case (state)
      S_PLLRST: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          retry_nxt = retry_cnt + 4'd1;
          cnt_nxt   = '0;
          state_nxt = (retry_nxt == RETRY_MAX) ? S_FAULT : S_PLLRST;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        retry_nxt = '0;
        cnt_nxt   = '0;
        // Lock loss and relock_req collapse into one restart; the sticky flag wins.
        if (!locked_s) begin
          state_nxt = S_PLLRST;
          lost_nxt  = 1'b1;
        end else if (relock_req) begin
          state_nxt = S_PLLRST;
        end
      end
      S_FAULT: begin
        cnt_nxt = '0;
        if (relock_req) begin
          state_nxt = S_PLLRST;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_PLLRST;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLLRST;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
      pll_rst   <= (state_nxt == S_PLLRST);
      sys_rst   <= (state_nxt != S_RUN);
      ready     <= (state_nxt == S_RUN);
      fault     <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters.
module tb_pll_lock_sequencer;

  localparam int unsigned P  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned S  = 8;
`ifdef PLL_SEQ_LOCK_SYNC_EN
  localparam int unsigned SL = 2;
`else
  localparam int unsigned SL = 0;
`endif

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int tests = 0;
  int fails = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (P),
    .LOCK_TIMEOUT_CYC (T),
    .LOCK_STABLE_CYC  (S),
    .MAX_RETRY        (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked     (locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   {3'b0, pll_rst},   4'h1);
    chk({tag, "_sys_rst"},   {3'b0, sys_rst},   4'h1);
    chk({tag, "_ready"},     {3'b0, ready},     4'h0);
    chk({tag, "_fault"},     {3'b0, fault},     4'h0);
    chk({tag, "_retry"},     retry_cnt,         4'h0);
    chk({tag, "_lock_lost"}, {3'b0, lock_lost}, 4'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    locked     = 1'b0;
    relock_req = 1'b0;
    tick(3);
    chk_reset_vals("reset");

    // Nominal bring-up
    rst_n = 1'b1;
    tick(P - 1);
    chk("nom_pll_rst_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("nom_pll_rst_lo", {3'b0, pll_rst}, 4'h0);
    tick(10);
    locked = 1'b1;
    tick(SL + S);
    chk("nom_ready_early", {3'b0, ready},   4'h0);
    chk("nom_sys_rst_hi",  {3'b0, sys_rst}, 4'h1);
    tick(1);
    chk("nom_ready",   {3'b0, ready},   4'h1);
    chk("nom_sys_rst", {3'b0, sys_rst}, 4'h0);
    chk("nom_retry",   retry_cnt,       4'h0);

    // Lock loss in S_RUN
    tick(2);
    locked = 1'b0;
    tick(SL);
    chk("loss_pll_rst_early", {3'b0, pll_rst}, 4'h0);
    chk("loss_ready_early",   {3'b0, ready},   4'h1);
    tick(1);
    chk("loss_pll_rst",   {3'b0, pll_rst},   4'h1);
    chk("loss_sys_rst",   {3'b0, sys_rst},   4'h1);
    chk("loss_ready",     {3'b0, ready},     4'h0);
    chk("loss_lock_lost", {3'b0, lock_lost}, 4'h1);
    tick(P - 1);
    chk("loss_pulse_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("loss_pulse_lo", {3'b0, pll_rst}, 4'h0);
    locked = 1'b1;
    tick(SL + S);
    chk("loss_rerun_early", {3'b0, ready}, 4'h0);
    tick(1);
    chk("loss_rerun_ready",  {3'b0, ready},     4'h1);
    chk("loss_sticky",       {3'b0, lock_lost}, 4'h1);

    // relock_req from S_RUN clears lock_lost and restarts
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("relock_sys_rst",   {3'b0, sys_rst},   4'h1);
    chk("relock_pll_rst",   {3'b0, pll_rst},   4'h1);
    chk("relock_lost_clr",  {3'b0, lock_lost}, 4'h0);
    tick(P - 1);
    chk("relock_pulse_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("relock_pulse_lo", {3'b0, pll_rst}, 4'h0);
    tick(S);
    chk("relock_ready_early", {3'b0, ready}, 4'h0);
    tick(1);
    chk("relock_ready", {3'b0, ready}, 4'h1);

    // Lock loss and relock_req together
    locked = 1'b0;
    tick(SL);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("simul_pll_rst",   {3'b0, pll_rst},   4'h1);
    chk("simul_lock_lost", {3'b0, lock_lost}, 4'h1);
    tick(P - 1);
    chk("simul_pulse_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("simul_pulse_lo", {3'b0, pll_rst}, 4'h0);

    // Retry to fault with locked held low
    tick(T - 1);
    chk("retry1_early_pll", {3'b0, pll_rst}, 4'h0);
    chk("retry1_early_cnt", retry_cnt,       4'h0);
    tick(1);
    chk("retry1_pll_rst", {3'b0, pll_rst}, 4'h1);
    chk("retry1_cnt",     retry_cnt,       4'h1);
    tick(P - 1);
    chk("retry1_pulse_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("retry1_pulse_lo", {3'b0, pll_rst}, 4'h0);
    tick(T - 1);
    chk("fault_early", {3'b0, fault}, 4'h0);
    tick(1);
    chk("fault_set",     {3'b0, fault},   4'h1);
    chk("fault_retry",   retry_cnt,       4'h2);
    chk("fault_pll_rst", {3'b0, pll_rst}, 4'h0);
    chk("fault_sys_rst", {3'b0, sys_rst}, 4'h1);
    tick(100);
    chk("fault_hold",         {3'b0, fault},   4'h1);
    chk("fault_hold_pll_rst", {3'b0, pll_rst}, 4'h0);
    chk("fault_hold_sys_rst", {3'b0, sys_rst}, 4'h1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk("fault_exit",       {3'b0, fault},     4'h0);
    chk("fault_exit_pll",   {3'b0, pll_rst},   4'h1);
    chk("fault_exit_retry", retry_cnt,         4'h0);
    chk("fault_exit_lost",  {3'b0, lock_lost}, 4'h0);

    // Glitchy lock: stable count restarts
    tick(P);
    chk("glitch_pll_rst_lo", {3'b0, pll_rst}, 4'h0);
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(SL + S);
    chk("glitch_ready_early", {3'b0, ready}, 4'h0);
    chk("glitch_retry_mid",   retry_cnt,     4'h0);
    tick(1);
    chk("glitch_ready", {3'b0, ready}, 4'h1);
    chk("glitch_retry", retry_cnt,     4'h0);

    // Asynchronous reset during S_STABLE
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(P + 1 + 3);
    chk("mid_in_stable_pll", {3'b0, pll_rst}, 4'h0);
    chk("mid_in_stable_rdy", {3'b0, ready},   4'h0);
    rst_n = 1'b0;
    #2;
    chk_reset_vals("mid_async");
    rst_n = 1'b1;
    tick(P - 1);
    chk("mid_pulse_hi", {3'b0, pll_rst}, 4'h1);
    tick(1);
    chk("mid_pulse_lo", {3'b0, pll_rst}, 4'h0);
    tick(S);
    chk("mid_ready_early", {3'b0, ready}, 4'h0);
    tick(1);
    chk("mid_ready", {3'b0, ready}, 4'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the core PLL: drives its reset, waits for `locked`, qualifies lock stability, then releases the core's system reset. Sits between the board reference clock and the 40/80 MHz PLL instance, re-sequences on loss of lock, retries on lock timeout, and latches a fault after repeated failures. Runs entirely in the 50 MHz reference clock domain.

## Interface
- `RST_PULSE_CYC`, default 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYC`, default 50000: cycles allowed in S_WAIT for lock (1 ms).
- `LOCK_STABLE_CYC`, default 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRY`, default 3: failed attempts before S_FAULT (1..15).

Ports:
- `refclk` in 1: 50 MHz reference clock, the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle request to re-run the sequence.
- `pll_rst` out 1: PLL reset, active high.
- `sys_rst` out 1: core reset, active high.
- `ready` out 1: high only in S_RUN.
- `fault` out 1: high only in S_FAULT.
- `retry_cnt` out 4: timeouts in the current sequence.
- `lock_lost` out 1: sticky; set on lock loss in S_RUN, cleared by `relock_req` or reset.

## Operation
- All outputs registered and decoded from the next state. Reset values: state S_PLLRST, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `lock_lost`=0, counters 0.
- `locked_s` is the qualified lock (see Configuration).
- S_PLLRST: `pll_rst`=1, `sys_rst`=1. Count RST_PULSE_CYC cycles, then go to S_WAIT with the counter cleared.
- S_WAIT: `pll_rst`=0. If `locked_s`=1, go to S_STABLE with the counter cleared. If the counter reaches LOCK_TIMEOUT_CYC-1 without lock, increment `retry_cnt`. If the new value equals MAX_RETRY, go to S_FAULT; otherwise go to S_PLLRST. If lock and timeout coincide, lock wins.
- S_STABLE: count cycles while `locked_s`=1. After LOCK_STABLE_CYC, go to S_RUN. If `locked_s` drops, return to S_WAIT with the counter cleared; `retry_cnt` is unchanged.
- S_RUN: `sys_rst`=0, `ready`=1, `retry_cnt` cleared. If `locked_s`=0, set `lock_lost` and go to S_PLLRST. `relock_req` also goes to S_PLLRST. If both occur in the same cycle, go to S_PLLRST once and set `lock_lost`.
- S_FAULT: `pll_rst`=0, `sys_rst`=1, `fault`=1. Only `relock_req` exits, to S_PLLRST with `retry_cnt` cleared.
- `relock_req` is ignored in S_PLLRST, S_WAIT and S_STABLE.
- `relock_req` always clears `lock_lost`, except in a cycle where lock loss sets it; set wins.
- Assertion of `rst_n` mid-sequence immediately forces the reset values. No wrap: counters saturate in their state and clear on every transition.

## Timing
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYC rising edges.
- `locked` to `locked_s` latency: 2 cycles with sync, 0 without.
- The first `locked_s`=1 cycle in S_WAIT causes entry to S_STABLE on the next edge.
- `ready` rises and `sys_rst` falls together, LOCK_STABLE_CYC edges after S_STABLE entry.
- Lock loss in S_RUN: `sys_rst`=1 and `pll_rst`=1 on the edge after `locked_s` falls.
- `relock_req` in S_RUN: `sys_rst`=1 on the next edge.

## Configuration
- `PLL_SEQ_LOCK_SYNC_EN` defined: `locked` passes through a 2-flop synchronizer reset to 0 by `rst_n`; `locked_s` lags `locked` by 2 cycles.
- `PLL_SEQ_LOCK_SYNC_EN` undefined: `locked_s` = `locked` directly, for simulation or an already-synchronous source. All other timing is unchanged.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum: S_PLLRST, S_WAIT, S_STABLE, S_RUN, S_FAULT;
  - default parameter constants;
  - a counter-width function: `$clog2` of the largest cycle parameter.
- Sub-module `pll_lock_sync`: 2-flop synchronizer, instantiated only under the macro.

## Test plan
Bench uses RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, MAX_RETRY=2, with sync enabled.
- Nominal: release `rst_n`, `locked` rises 10 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles; `ready`=1 and `sys_rst`=0 exactly 2+1+8 cycles after the `locked` rise.
- Glitchy lock: `locked` high 5 cycles, low 1 cycle, then high → the stable count restarts and `ready` is delayed accordingly; `retry_cnt` stays 0.
- Retry to fault: `locked` held 0 → two 4-cycle `pll_rst` pulses 32 cycles apart, `retry_cnt` reaches 2, `fault`=1, `sys_rst`=1 and `pll_rst`=0 hold indefinitely; `relock_req` restarts with `retry_cnt`=0.
- Lock loss in run: drop `locked` in S_RUN → `sys_rst` and `pll_rst` high 3 cycles after the fall, `lock_lost`=1; the full sequence reruns to `ready`.
- Simultaneous: `relock_req` in the same cycle `locked_s` falls in S_RUN → a single re-sequence and `lock_lost`=1.
- Mid-sequence reset: assert `rst_n` during S_STABLE → all outputs return to reset values asynchronously, and the sequence restarts with a 4-cycle pulse.
